// File: rtl/sc_dmem_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Owner encoding, FSM states, address-decode bit positions and burst helpers.
package sc_dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN_CPU = 2'd1,
        S_OWN_DMA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    localparam int IO_SEL_BIT = 7;
    localparam int RAM_IDX_HI = 6;
    localparam int RAM_IDX_LO = 2;
    localparam int RAM_IDX_W  = RAM_IDX_HI - RAM_IDX_LO + 1;
    localparam int BURST_W    = 4;

    // Grant vector bit positions follow the owner encoding.
    localparam int GNT_CPU = 0;
    localparam int GNT_DMA = 1;

    // Saturate so a lone requester streaming forever cannot wrap to a small count.
    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] b);
        return (b == '1) ? b : b + 1'b1;
    endfunction

endpackage

// File: rtl/sc_dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter, the data RAM and I/O.
// master = requester/memory side, slave = arbiter side.
interface sc_dmem_arbiter_if;
    import sc_dmem_pkg::*;

    logic                 cpu_req, cpu_we;
    logic [31:0]          cpu_addr, cpu_wdata;
    logic                 cpu_gnt, cpu_rvalid;
    logic [31:0]          cpu_rdata;

    logic                 dma_req, dma_we;
    logic [31:0]          dma_addr, dma_wdata;
    logic                 dma_gnt, dma_rvalid;
    logic [31:0]          dma_rdata;

    logic [RAM_IDX_W-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_we;
    logic [31:0]          mem_rdata;
    logic                 io_we;
    logic [31:0]          io_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, io_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_we, io_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, io_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_we, io_we
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection: burst fairness while owned, tie rule from IDLE.
// Define DMEM_ARB_RR_EN for round-robin IDLE ties; otherwise the CPU wins them.
module dmem_arb_pick
    import sc_dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               i_cpu_req,
    input  logic               i_dma_req,
    input  arb_state_t         i_state,
    input  logic [BURST_W-1:0] i_burst,
    input  owner_t             i_last_winner,
    output logic [1:0]         o_gnt
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
    localparam logic [1:0] W_CPU = 2'b01;
    localparam logic [1:0] W_DMA = 2'b10;

`ifndef DMEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last_winner;
`endif

    always_comb begin
        o_gnt = {i_dma_req, i_cpu_req};
        if (i_cpu_req && i_dma_req) begin
            case (i_state)
                S_OWN_CPU: o_gnt = (i_burst < MAX_B) ? W_CPU : W_DMA;
                S_OWN_DMA: o_gnt = (i_burst < MAX_B) ? W_DMA : W_CPU;
                default: begin
`ifdef DMEM_ARB_RR_EN
                    o_gnt = (i_last_winner == OWNER_DMA) ? W_CPU : W_DMA;
`else
                    o_gnt = W_CPU;
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Zero-wait CPU/DMA arbiter for a 32-word data RAM plus I/O space (addr[7]).
// Owns the FSM, burst counter, last-winner bit and one-cycle read-return path.
module sc_dmem_arbiter
    import sc_dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset,
    sc_dmem_arbiter_if.slave   bus
);

    arb_state_t         r_state, w_state_next;
    logic [BURST_W-1:0] r_burst, w_burst_next;
    owner_t             r_last, w_last_next;
    logic               r_ret_io;

    logic [1:0]  w_pick, w_gnt, w_req_we, w_rvalid;
    logic        w_any;
    logic [31:0] w_sel_addr, w_sel_wdata, w_ret_data;
    logic        w_sel_we;
    logic [31:0] w_rdata [2];
    logic        w_unused_addr;

    dmem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .i_cpu_req     (bus.cpu_req),
        .i_dma_req     (bus.dma_req),
        .i_state       (r_state),
        .i_burst       (r_burst),
        .i_last_winner (r_last),
        .o_gnt         (w_pick)
    );

    // Grants are combinational, so reset must mask them directly.
    assign w_gnt       = reset ? 2'b00 : w_pick;
    assign w_any       = |w_gnt;
    assign w_sel_addr  = w_gnt[GNT_DMA] ? bus.dma_addr  : bus.cpu_addr;
    assign w_sel_wdata = w_gnt[GNT_DMA] ? bus.dma_wdata : bus.cpu_wdata;
    assign w_sel_we    = w_gnt[GNT_DMA] ? bus.dma_we    : bus.cpu_we;
    assign w_unused_addr = ^{w_sel_addr[31:IO_SEL_BIT+1], w_sel_addr[RAM_IDX_LO-1:0]};

    assign bus.cpu_gnt   = w_gnt[GNT_CPU];
    assign bus.dma_gnt   = w_gnt[GNT_DMA];
    assign bus.mem_addr  = w_any ? w_sel_addr[RAM_IDX_HI:RAM_IDX_LO] : '0;
    assign bus.mem_wdata = w_any ? w_sel_wdata : '0;
    assign bus.mem_we    = w_any & w_sel_we & ~w_sel_addr[IO_SEL_BIT];
    assign bus.io_we     = w_any & w_sel_we &  w_sel_addr[IO_SEL_BIT];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_burst  <= '0;
            r_last   <= OWNER_DMA;
            r_ret_io <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_burst  <= w_burst_next;
            r_last   <= w_last_next;
            r_ret_io <= w_sel_addr[IO_SEL_BIT];
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        w_burst_next = '0;
        w_last_next  = r_last;
        if (w_gnt[GNT_CPU]) begin
            w_state_next = S_OWN_CPU;
            w_last_next  = OWNER_CPU;
            w_burst_next = (r_state == S_OWN_CPU) ? burst_inc(r_burst) : BURST_W'(1);
        end else if (w_gnt[GNT_DMA]) begin
            w_state_next = S_OWN_DMA;
            w_last_next  = OWNER_DMA;
            w_burst_next = (r_state == S_OWN_DMA) ? burst_inc(r_burst) : BURST_W'(1);
        end
    end

    // Only one read can be outstanding, so a single return mux serves both requesters.
    assign w_req_we   = {bus.dma_we, bus.cpu_we};
    assign w_ret_data = r_ret_io ? bus.io_rdata : bus.mem_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic        r_pend;
            logic [31:0] r_rdata;

            assign w_rvalid[gi] = r_pend & ~reset;
            assign w_rdata[gi]  = w_rvalid[gi] ? w_ret_data : r_rdata;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_pend  <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_pend  <= w_gnt[gi] & ~w_req_we[gi];
                    r_rdata <= w_rdata[gi];
                end
            end
        end
    endgenerate

    assign bus.cpu_rvalid = w_rvalid[GNT_CPU];
    assign bus.dma_rvalid = w_rvalid[GNT_DMA];
    assign bus.cpu_rdata  = w_rdata[GNT_CPU];
    assign bus.dma_rdata  = w_rdata[GNT_DMA];

endmodule
